// File: rtl/mem_req_sequencer_if.sv
// rtl/mem_req_sequencer_if.sv - cache request valid/ack bundle between the MEM-stage sequencer and the cache
interface mem_req_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_rw;
  logic              req_ack;

  modport master (
    output req_valid,
    output req_addr,
    output req_rw,
    input  req_ack
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_rw,
    output req_ack
  );
endinterface

// File: rtl/mem_req_sequencer.sv
// rtl/mem_req_sequencer.sv - MEM-stage cache request sequencer; MEM_REQ_PERF_CNT_EN enables perf counters
module mem_req_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] mem_addr1_in,
  input  logic [ADDR_W-1:0] mem_addr1_end_in,
  input  logic [ADDR_W-1:0] mem_addr2_in,
  input  logic [ADDR_W-1:0] mem_addr2_end_in,
  input  logic [1:0]        mem1_rw_in,
  input  logic [1:0]        mem2_rw_in,
  input  logic              downstream_stall,
  output logic              latch_ld,
  output logic              done_valid,
  output logic [31:0]       perf_req_cnt,
  output logic [31:0]       perf_stall_cnt,
  mem_req_sequencer_if.master req
);

  localparam int TAG_W = ADDR_W - LINE_BITS;

  typedef enum logic [2:0] {IDLE, M1A, M1B, M2A, M2B, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr1, addr2;
  logic [TAG_W-1:0]  end1_tag, end2_tag;
  logic [1:0]        rw1, rw2;
  logic              split1, split2;

  logic              split1_in, split2_in;
  logic [3:0]        need_in, need;
  logic              capture;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [1:0]        issue_rw;

  // Only the end-address line tags matter: they drive split detection and the high-line base.
  assign split1_in = mem_addr1_in[ADDR_W-1:LINE_BITS] != mem_addr1_end_in[ADDR_W-1:LINE_BITS];
  assign split2_in = mem_addr2_in[ADDR_W-1:LINE_BITS] != mem_addr2_end_in[ADDR_W-1:LINE_BITS];

  // need bit order matches request order: {M2B, M2A, M1B, M1A}
  assign need_in = {(mem2_rw_in != 2'b00) && split2_in, mem2_rw_in != 2'b00,
                    (mem1_rw_in != 2'b00) && split1_in, mem1_rw_in != 2'b00};
  assign need    = {(rw2 != 2'b00) && split2, rw2 != 2'b00,
                    (rw1 != 2'b00) && split1, rw1 != 2'b00};

  function automatic state_t first_needed(input logic [3:0] n);
    if (n[0])      return M1A;
    else if (n[1]) return M1B;
    else if (n[2]) return M2A;
    else if (n[3]) return M2B;
    else           return DONE;
  endfunction

  // Next-state and output decode; flush overrides everything except clr.
  always_comb begin
    state_nxt   = state;
    latch_ld    = 1'b0;
    done_valid  = 1'b0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    issue_rw    = 2'b00;
    capture     = 1'b0;
    unique case (state)
      IDLE: begin
        latch_ld = !valid_in;
        if (valid_in) begin
          capture   = 1'b1;
          state_nxt = first_needed(need_in);
        end
      end
      M1A: begin
        issue_valid = 1'b1;
        issue_addr  = addr1;
        issue_rw    = rw1;
        if (req.req_ack) state_nxt = first_needed(need & 4'b1110);
      end
      M1B: begin
        issue_valid = 1'b1;
        issue_addr  = {end1_tag, {LINE_BITS{1'b0}}};
        issue_rw    = rw1;
        if (req.req_ack) state_nxt = first_needed(need & 4'b1100);
      end
      M2A: begin
        issue_valid = 1'b1;
        issue_addr  = addr2;
        issue_rw    = rw2;
        if (req.req_ack) state_nxt = first_needed(need & 4'b1000);
      end
      M2B: begin
        issue_valid = 1'b1;
        issue_addr  = {end2_tag, {LINE_BITS{1'b0}}};
        issue_rw    = rw2;
        if (req.req_ack) state_nxt = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        latch_ld   = !downstream_stall;
        if (!downstream_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      latch_ld  = 1'b1;
      state_nxt = IDLE;
      capture   = 1'b0;
    end
  end

  // State register and operand capture; flush and clr both drop captured data.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      addr1    <= '0;
      addr2    <= '0;
      end1_tag <= '0;
      end2_tag <= '0;
      rw1      <= 2'b00;
      rw2      <= 2'b00;
      split1   <= 1'b0;
      split2   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        addr1    <= '0;
        addr2    <= '0;
        end1_tag <= '0;
        end2_tag <= '0;
        rw1      <= 2'b00;
        rw2      <= 2'b00;
        split1   <= 1'b0;
        split2   <= 1'b0;
      end else if (capture) begin
        addr1    <= mem_addr1_in;
        addr2    <= mem_addr2_in;
        end1_tag <= mem_addr1_end_in[ADDR_W-1:LINE_BITS];
        end2_tag <= mem_addr2_end_in[ADDR_W-1:LINE_BITS];
        rw1      <= mem1_rw_in;
        rw2      <= mem2_rw_in;
        split1   <= split1_in;
        split2   <= split2_in;
      end
    end
  end

  assign req.req_valid = issue_valid;
  assign req.req_addr  = issue_addr;
  assign req.req_rw    = issue_rw;

`ifdef MEM_REQ_PERF_CNT_EN
  logic [31:0] req_cnt, stall_cnt;

  // Accepted-request and held-latch counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (clr) begin
      req_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue_valid && req.req_ack && !flush) req_cnt <= req_cnt + 32'd1;
      if (!latch_ld) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_req_cnt   = req_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_req_cnt   = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb/tb_mem_req_sequencer.sv - scoreboard bench for mem_req_sequencer
`timescale 1ns/1ps
module tb_mem_req_sequencer;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  rw;
  } req_t;

`ifdef MEM_REQ_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr, flush, valid_in, downstream_stall;
  logic [31:0] a1, e1, a2, e2;
  logic [1:0]  rw1, rw2;
  logic        latch_ld, done_valid;
  logic [31:0] perf_req_cnt, perf_stall_cnt;

  mem_req_sequencer_if #(.ADDR_W(32)) req_if ();

  mem_req_sequencer #(.ADDR_W(32), .LINE_BITS(4)) dut (
    .clk              (clk),
    .clr              (clr),
    .flush            (flush),
    .valid_in         (valid_in),
    .mem_addr1_in     (a1),
    .mem_addr1_end_in (e1),
    .mem_addr2_in     (a2),
    .mem_addr2_end_in (e2),
    .mem1_rw_in       (rw1),
    .mem2_rw_in       (rw2),
    .downstream_stall (downstream_stall),
    .latch_ld         (latch_ld),
    .done_valid       (done_valid),
    .perf_req_cnt     (perf_req_cnt),
    .perf_stall_cnt   (perf_stall_cnt),
    .req              (req_if.master)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  req_t        exp_q[$];
  req_t        got_q[$];
  int          hold_q[$];
  logic [63:0] ld_vec, done_vec;
  int          n_cyc, hold_err;
  bit          timed_out;
  logic [31:0] exp_req_cnt = 0;
  logic [31:0] exp_stall_cnt = 0;

  // Drives one instruction and services its requests; records what the DUT did.
  task automatic run_instr(input logic [31:0] i_a1, i_e1, i_a2, i_e2,
                           input logic [1:0] i_rw1, i_rw2,
                           input int ack_dly, input int stall_n);
    int          wait_cnt = 0;
    int          stall_left = stall_n;
    int          held = 0;
    bit          fin = 0;
    logic [31:0] last_addr = '0;
    logic [1:0]  last_rw = '0;
    got_q.delete();
    hold_q.delete();
    ld_vec = '0;
    done_vec = '0;
    hold_err = 0;
    n_cyc = 0;
    @(negedge clk);
    valid_in = 1'b1;
    a1 = i_a1; e1 = i_e1; a2 = i_a2; e2 = i_e2;
    rw1 = i_rw1; rw2 = i_rw2;
    while (!fin && n_cyc < 60) begin
      req_if.req_ack = req_if.req_valid && (wait_cnt >= ack_dly);
      downstream_stall = (stall_left > 0);
      #1;
      ld_vec[n_cyc] = latch_ld;
      done_vec[n_cyc] = done_valid;
      n_cyc++;
      if (req_if.req_valid === 1'b1) begin
        if (held > 0 && (req_if.req_addr !== last_addr || req_if.req_rw !== last_rw)) hold_err++;
        last_addr = req_if.req_addr;
        last_rw = req_if.req_rw;
        held++;
        if (req_if.req_ack) begin
          got_q.push_back({req_if.req_addr, req_if.req_rw});
          hold_q.push_back(held);
          held = 0;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      if (done_valid === 1'b1) begin
        if (stall_left > 0) stall_left--;
        else fin = 1;
      end
      @(negedge clk);
      valid_in = 1'b0;
      req_if.req_ack = 1'b0;
      downstream_stall = 1'b0;
    end
    timed_out = !fin;
  endtask

  task automatic test_reset();
    clr = 1'b1; flush = 1'b0; valid_in = 1'b0; downstream_stall = 1'b0;
    a1 = '0; e1 = '0; a2 = '0; e2 = '0; rw1 = '0; rw2 = '0;
    req_if.req_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++; if (req_if.req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", req_if.req_valid); else passed++;
    checks++; if (done_valid !== 1'b0) $display("FAIL reset_done_valid: got %b expected 0", done_valid); else passed++;
    checks++; if (latch_ld !== 1'b1) $display("FAIL reset_latch_ld: got %b expected 1", latch_ld); else passed++;
    checks++; if (req_if.req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h expected 0", req_if.req_addr); else passed++;
    checks++; if (perf_req_cnt !== 32'h0) $display("FAIL reset_perf_req: got %h expected 0", perf_req_cnt); else passed++;
    checks++; if (perf_stall_cnt !== 32'h0) $display("FAIL reset_perf_stall: got %h expected 0", perf_stall_cnt); else passed++;
  endtask

  task automatic test_single_read();
    exp_q.push_back({32'h1000, 2'b01});
    run_instr(32'h1000, 32'h1003, 32'h0, 32'h0, 2'b01, 2'b00, 0, 0);
    exp_req_cnt += 1; exp_stall_cnt += 2;
    checks++; if (timed_out) $display("FAIL single_timeout: got timeout expected done within 60 cycles"); else passed++;
    checks++; if (n_cyc !== 3) $display("FAIL single_cycles: got %0d expected 3", n_cyc); else passed++;
    checks++; if (done_vec[2:0] !== 3'b100) $display("FAIL single_done_trace: got %b expected 100", done_vec[2:0]); else passed++;
    checks++; if (ld_vec[2:0] !== 3'b100) $display("FAIL single_ld_trace: got %b expected 100", ld_vec[2:0]); else passed++;
    while (exp_q.size() > 0) begin
      req_t e, g;
      e = exp_q.pop_front();
      g = '0;
      if (got_q.size() > 0) g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL single_req: got %h/%b expected %h/%b", g.addr, g.rw, e.addr, e.rw); else passed++;
    end
    checks++; if (got_q.size() !== 0) $display("FAIL single_extra_req: got %0d extra expected 0", got_q.size()); else passed++;
    checks++; if (perf_req_cnt !== (PERF_ON ? exp_req_cnt : 32'h0)) $display("FAIL single_perf_req: got %0d expected %0d", perf_req_cnt, PERF_ON ? exp_req_cnt : 32'h0); else passed++;
    checks++; if (perf_stall_cnt !== (PERF_ON ? exp_stall_cnt : 32'h0)) $display("FAIL single_perf_stall: got %0d expected %0d", perf_stall_cnt, PERF_ON ? exp_stall_cnt : 32'h0); else passed++;
  endtask

  task automatic test_split_both();
    exp_q.push_back({32'h100E, 2'b01});
    exp_q.push_back({32'h1010, 2'b01});
    exp_q.push_back({32'h2FFC, 2'b10});
    exp_q.push_back({32'h3000, 2'b10});
    run_instr(32'h100E, 32'h1011, 32'h2FFC, 32'h3003, 2'b01, 2'b10, 2, 0);
    exp_req_cnt += 4; exp_stall_cnt += 13;
    checks++; if (n_cyc !== 14) $display("FAIL split_cycles: got %0d expected 14", n_cyc); else passed++;
    checks++; if (done_vec !== (64'h1 << 13)) $display("FAIL split_done_trace: got %h expected %h", done_vec, 64'h1 << 13); else passed++;
    checks++; if (hold_err !== 0) $display("FAIL split_hold_stable: got %0d changes expected 0", hold_err); else passed++;
    for (int i = 0; i < 4; i++) begin
      int h;
      h = (hold_q.size() > 0) ? hold_q.pop_front() : 0;
      checks++; if (h !== 3) $display("FAIL split_hold_len%0d: got %0d expected 3", i, h); else passed++;
    end
    while (exp_q.size() > 0) begin
      req_t e, g;
      e = exp_q.pop_front();
      g = '0;
      if (got_q.size() > 0) g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL split_req: got %h/%b expected %h/%b", g.addr, g.rw, e.addr, e.rw); else passed++;
    end
    checks++; if (got_q.size() !== 0) $display("FAIL split_extra_req: got %0d extra expected 0", got_q.size()); else passed++;
    checks++; if (perf_req_cnt !== (PERF_ON ? exp_req_cnt : 32'h0)) $display("FAIL split_perf_req: got %0d expected %0d", perf_req_cnt, PERF_ON ? exp_req_cnt : 32'h0); else passed++;
  endtask

  task automatic test_downstream_stall();
    exp_q.push_back({32'h4000, 2'b10});
    run_instr(32'h4000, 32'h4007, 32'h0, 32'h0, 2'b10, 2'b00, 0, 3);
    exp_req_cnt += 1; exp_stall_cnt += 5;
    checks++; if (n_cyc !== 6) $display("FAIL stall_cycles: got %0d expected 6", n_cyc); else passed++;
    checks++; if (done_vec[5:0] !== 6'b111100) $display("FAIL stall_done_trace: got %b expected 111100", done_vec[5:0]); else passed++;
    checks++; if (ld_vec[5:0] !== 6'b100000) $display("FAIL stall_ld_trace: got %b expected 100000", ld_vec[5:0]); else passed++;
    while (exp_q.size() > 0) begin
      req_t e, g;
      e = exp_q.pop_front();
      g = '0;
      if (got_q.size() > 0) g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL stall_req: got %h/%b expected %h/%b", g.addr, g.rw, e.addr, e.rw); else passed++;
    end
    checks++; if (perf_stall_cnt !== (PERF_ON ? exp_stall_cnt : 32'h0)) $display("FAIL stall_perf_stall: got %0d expected %0d", perf_stall_cnt, PERF_ON ? exp_stall_cnt : 32'h0); else passed++;
  endtask

  task automatic test_flush_mid_request();
    bit saw_done = 0;
    @(negedge clk);
    valid_in = 1'b1; a1 = 32'h100E; e1 = 32'h1011; a2 = '0; e2 = '0; rw1 = 2'b01; rw2 = 2'b00;
    #1;
    checks++; if (latch_ld !== 1'b0) $display("FAIL flush_c1_ld: got %b expected 0", latch_ld); else passed++;
    @(negedge clk);
    valid_in = 1'b0; req_if.req_ack = 1'b1;
    #1;
    checks++; if (req_if.req_addr !== 32'h100E) $display("FAIL flush_m1a_addr: got %h expected 100e", req_if.req_addr); else passed++;
    @(negedge clk);
    req_if.req_ack = 1'b1; flush = 1'b1;
    #1;
    checks++; if (req_if.req_valid !== 1'b1 || req_if.req_addr !== 32'h1010) $display("FAIL flush_m1b_req: got %b/%h expected 1/1010", req_if.req_valid, req_if.req_addr); else passed++;
    checks++; if (latch_ld !== 1'b1) $display("FAIL flush_cycle_ld: got %b expected 1", latch_ld); else passed++;
    @(negedge clk);
    req_if.req_ack = 1'b0; flush = 1'b0;
    #1;
    checks++; if (req_if.req_valid !== 1'b0 || req_if.req_addr !== 32'h0) $display("FAIL flush_after_req: got %b/%h expected 0/0", req_if.req_valid, req_if.req_addr); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (done_valid !== 1'b0) saw_done = 1;
      @(negedge clk);
      #1;
    end
    checks++; if (saw_done !== 1'b0) $display("FAIL flush_no_done: got %b expected 0", saw_done); else passed++;
    exp_req_cnt += 1; exp_stall_cnt += 2;
    checks++; if (perf_req_cnt !== (PERF_ON ? exp_req_cnt : 32'h0)) $display("FAIL flush_perf_req: got %0d expected %0d", perf_req_cnt, PERF_ON ? exp_req_cnt : 32'h0); else passed++;
    checks++; if (perf_stall_cnt !== (PERF_ON ? exp_stall_cnt : 32'h0)) $display("FAIL flush_perf_stall: got %0d expected %0d", perf_stall_cnt, PERF_ON ? exp_stall_cnt : 32'h0); else passed++;
  endtask

  task automatic test_no_access();
    run_instr(32'h5000, 32'h5003, 32'h6000, 32'h6003, 2'b00, 2'b00, 0, 0);
    exp_stall_cnt += 1;
    checks++; if (n_cyc !== 2) $display("FAIL noacc_cycles: got %0d expected 2", n_cyc); else passed++;
    checks++; if (done_vec[1:0] !== 2'b10) $display("FAIL noacc_done_trace: got %b expected 10", done_vec[1:0]); else passed++;
    checks++; if (ld_vec[1:0] !== 2'b10) $display("FAIL noacc_ld_trace: got %b expected 10", ld_vec[1:0]); else passed++;
    checks++; if (got_q.size() !== 0) $display("FAIL noacc_reqs: got %0d expected 0", got_q.size()); else passed++;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({32'h20FF, 2'b10});
    exp_q.push_back({32'h2100, 2'b10});
    run_instr(32'h0, 32'h0, 32'h20FF, 32'h2100, 2'b00, 2'b10, 0, 0);
    exp_req_cnt += 2; exp_stall_cnt += 3;
    checks++; if (n_cyc !== 4) $display("FAIL op2split_cycles: got %0d expected 4", n_cyc); else passed++;
    while (exp_q.size() > 0) begin
      req_t e, g;
      e = exp_q.pop_front();
      g = '0;
      if (got_q.size() > 0) g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL op2split_req: got %h/%b expected %h/%b", g.addr, g.rw, e.addr, e.rw); else passed++;
    end
    exp_q.push_back({32'h1000, 2'b11});
    run_instr(32'h1000, 32'h100F, 32'h0, 32'h0, 2'b11, 2'b00, 0, 0);
    exp_req_cnt += 1; exp_stall_cnt += 2;
    checks++; if (n_cyc !== 3) $display("FAIL lineend_cycles: got %0d expected 3", n_cyc); else passed++;
    while (exp_q.size() > 0) begin
      req_t e, g;
      e = exp_q.pop_front();
      g = '0;
      if (got_q.size() > 0) g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL lineend_req: got %h/%b expected %h/%b", g.addr, g.rw, e.addr, e.rw); else passed++;
    end
    checks++; if (got_q.size() !== 0) $display("FAIL lineend_extra_req: got %0d extra expected 0", got_q.size()); else passed++;
    checks++; if (perf_req_cnt !== (PERF_ON ? exp_req_cnt : 32'h0)) $display("FAIL b2b_perf_req: got %0d expected %0d", perf_req_cnt, PERF_ON ? exp_req_cnt : 32'h0); else passed++;
    checks++; if (perf_stall_cnt !== (PERF_ON ? exp_stall_cnt : 32'h0)) $display("FAIL b2b_perf_stall: got %0d expected %0d", perf_stall_cnt, PERF_ON ? exp_stall_cnt : 32'h0); else passed++;
  endtask

  task automatic test_clr_mid_request();
    @(negedge clk);
    valid_in = 1'b1; a1 = 32'h3000; e1 = 32'h3003; rw1 = 2'b01; rw2 = 2'b00;
    @(negedge clk);
    valid_in = 1'b0; clr = 1'b1;
    #1;
    checks++; if (req_if.req_valid !== 1'b1 || req_if.req_addr !== 32'h3000) $display("FAIL clr_cycle_req: got %b/%h expected 1/3000", req_if.req_valid, req_if.req_addr); else passed++;
    @(negedge clk);
    clr = 1'b0;
    #1;
    exp_req_cnt = 0; exp_stall_cnt = 0;
    checks++; if (req_if.req_valid !== 1'b0 || req_if.req_addr !== 32'h0) $display("FAIL clr_after_req: got %b/%h expected 0/0", req_if.req_valid, req_if.req_addr); else passed++;
    checks++; if (latch_ld !== 1'b1) $display("FAIL clr_after_ld: got %b expected 1", latch_ld); else passed++;
    checks++; if (perf_req_cnt !== exp_req_cnt || perf_stall_cnt !== exp_stall_cnt) $display("FAIL clr_perf: got %0d/%0d expected 0/0", perf_req_cnt, perf_stall_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_split_both();
    test_downstream_stall();
    test_flush_mid_request();
    test_no_access();
    test_back_to_back();
    test_clr_mid_request();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
